ram_mport: RTL

Parametrised multi-port word RAM that generalises the three-read/one-write memory ports of the accelerator's AXI DMA path (mm2s read channels, s2mm strobed write channel) into a synthesizable block. It provides NR independent read ports with a configurable fixed read latency and one byte-strobed write port. It sits behind the DMA engines in `top_ram`-style integrations and replaces the DPI byte-array memory wherever a self-contained RAM is needed.

---
 rtl/ram_mport.sv | 117 +++++++++++
 1 files changed

// File: rtl/ram_mport.sv
// Multi-port word RAM: NR fixed-latency read ports and one byte-strobed write port.
// Define RAM_WR_FWD_EN for write-first collisions; leave it undefined for read-first.
module ram_mport #(
    parameter int NR             = 3,
    parameter int AXI_WIDTH      = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LSB            = $clog2(AXI_WIDTH) - 3,
    parameter int DEPTH_LOG2     = 10,
    parameter int RD_LAT         = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NR-1:0]                         rd_en,
    input  logic [NR*(AXI_ADDR_WIDTH-LSB)-1:0]    rd_addr,
    output logic [NR*AXI_WIDTH-1:0]               rd_data,
    output logic [NR-1:0]                         rd_valid,
    input  logic                                  wr_en,
    input  logic [AXI_ADDR_WIDTH-LSB-1:0]         wr_addr,
    input  logic [AXI_WIDTH-1:0]                  wr_data,
    input  logic [AXI_WIDTH/8-1:0]                wr_strb
);

    localparam int AW    = AXI_ADDR_WIDTH - LSB;
    localparam int NB    = AXI_WIDTH / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [AXI_WIDTH-1:0]  mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_idx_s;
    logic                  unused_addr_s;

    // Bytes with a set strobe come from the new word, the rest from the old one.
    function automatic logic [AXI_WIDTH-1:0] merge_bytes(
        input logic [AXI_WIDTH-1:0] old_word,
        input logic [AXI_WIDTH-1:0] new_word,
        input logic [NB-1:0]        strb
    );
        logic [AXI_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                merged[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

    // Upper address bits only alias the storage, so they are deliberately dropped.
    assign wr_idx_s      = wr_addr[DEPTH_LOG2-1:0];
    assign unused_addr_s = ^{rd_addr, wr_addr};

    // Storage write; contents are intentionally not reset and survive rst.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_r[wr_idx_s] <= merge_bytes(mem_r[wr_idx_s], wr_data, wr_strb);
        end
    end

    for (genvar p = 0; p < NR; p++) begin : g_port
        logic [DEPTH_LOG2-1:0] rd_idx_s;
        logic [AXI_WIDTH-1:0]  rd_word_s;
        logic [RD_LAT-1:0]     vld_c_s;
        logic [AXI_WIDTH-1:0]  dat_c_s [RD_LAT];
        logic [RD_LAT-1:0]     vld_r;
        logic [AXI_WIDTH-1:0]  dat_r [RD_LAT];

        assign rd_idx_s = rd_addr[p*AW +: DEPTH_LOG2];

        // Word sampled at the issue edge, with same-edge write merged when forwarding.
        always_comb begin
            rd_word_s = mem_r[rd_idx_s];
`ifdef RAM_WR_FWD_EN
            if (wr_en && (wr_idx_s == rd_idx_s)) begin
                rd_word_s = merge_bytes(mem_r[rd_idx_s], wr_data, wr_strb);
            end else begin
                rd_word_s = mem_r[rd_idx_s];
            end
`endif
        end

        // Stage inputs: stage 0 takes the fresh request, later stages the previous one.
        always_comb begin
            vld_c_s    = {RD_LAT{1'b0}};
            for (int k = 0; k < RD_LAT; k++) begin
                dat_c_s[k] = '0;
            end
            vld_c_s[0] = rd_en[p];
            dat_c_s[0] = rd_word_s;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_c_s[k] = vld_r[k-1];
                dat_c_s[k] = dat_r[k-1];
            end
        end

        // Read pipeline; data stages load only with a valid so the output holds.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_r <= {RD_LAT{1'b0}};
                for (int k = 0; k < RD_LAT; k++) begin
                    dat_r[k] <= '0;
                end
            end else begin
                vld_r <= vld_c_s;
                for (int k = 0; k < RD_LAT; k++) begin
                    if (vld_c_s[k]) begin
                        dat_r[k] <= dat_c_s[k];
                    end
                end
            end
        end

        assign rd_valid[p]                       = vld_r[RD_LAT-1];
        assign rd_data[p*AXI_WIDTH +: AXI_WIDTH] = dat_r[RD_LAT-1];
    end

endmodule
